// File: rtl/scrambler.sv
// rtl/scrambler.sv - additive x^7+x^4+1 bit scrambler/descrambler, one bit per clock
module scrambler #(
    parameter logic [6:0] SEED = 7'b1111111
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Input,
    output logic Output
);

    // state[6] is x7 (oldest), state[0] is x1 (newest)
    logic [6:0] state;
    logic       seq_bit;

    assign seq_bit = state[6] ^ state[3];
    assign Output  = Input ^ seq_bit;

    // Input never feeds the register, so scrambling and descrambling share one structure
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= SEED;
        end else begin
            state <= {state[5:0], seq_bit};
        end
    end

endmodule

// File: tb/tb_scrambler.sv
// tb/tb_scrambler.sv - directed-vector self-checking bench for scrambler
module tb_scrambler;

    logic clk;
    logic resetn;
    logic din;
    logic scr_out;
    logic dsc_out;
    logic pass_out;

    int checks;
    int errors;

    logic [126:0] ref_seq;
    logic [15:0]  ones_ref;
    logic [499:0] rnd_bits;

    scrambler dut (
        .Clock  (clk),
        .Reset  (resetn),
        .Input  (din),
        .Output (scr_out)
    );

    scrambler dut_rx (
        .Clock  (clk),
        .Reset  (resetn),
        .Input  (scr_out),
        .Output (dsc_out)
    );

    scrambler #(.SEED(7'b0000000)) dut_zero (
        .Clock  (clk),
        .Reset  (resetn),
        .Input  (din),
        .Output (pass_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetn   = 1'b1;
        din      = 1'b0;
        ref_seq  = 127'b0000111011110010110010010000001000100110001011101011011000001100110101001110011110110100001010101111101001010001101110001111111;
        ones_ref = 16'b1111000100001101;
        for (int i = 0; i < 500; i++) rnd_bits[i] = 1'($urandom_range(0, 1));

        // reset held low for several edges: state pinned at seed, output 0
        resetn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("hold_out", {6'd0, scr_out}, 7'd0);
            check_val("hold_state", dut.state, 7'b1111111);
        end
        resetn = 1'b1;
        #1;

        // first period, bit 1 first
        for (int i = 0; i < 127; i++) begin
            check_val($sformatf("seq_bit%0d", i + 1), {6'd0, scr_out}, {6'd0, ref_seq[126 - i]});
            step();
        end
        // second period must repeat with no discontinuity
        for (int i = 0; i < 127; i++) begin
            check_val($sformatf("wrap_bit%0d", i + 128), {6'd0, scr_out}, {6'd0, ref_seq[126 - i]});
            step();
        end

        // all-ones input gives complemented sequence
        do_reset();
        din = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("ones_bit%0d", i + 1), {6'd0, scr_out}, {6'd0, ones_ref[15 - i]});
            step();
        end

        // mid-stream reset restarts at bit 1
        din = 1'b0;
        do_reset();
        for (int i = 0; i < 50; i++) step();
        do_reset();
        check_val("restart_state", dut.state, 7'b1111111);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("restart_bit%0d", i + 1), {6'd0, scr_out}, {6'd0, ref_seq[126 - i]});
            step();
        end

        // round trip through descrambler; zero-seed instance is pass-through
        do_reset();
        for (int i = 0; i < 500; i++) begin
            din = rnd_bits[i];
            #1;
            check_val($sformatf("rt_bit%0d", i), {6'd0, dsc_out}, {6'd0, rnd_bits[i]});
            if (i % 25 == 0)
                check_val($sformatf("zero_seed_bit%0d", i), {6'd0, pass_out}, {6'd0, rnd_bits[i]});
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
